// File: rtl/spi_3wire_responder_if.sv
// Pin and register-bank bundle for the 3-wire SPI responder.
// reg_wr_en / reg_rd_en are single-cycle strobes with no back-pressure; reg_rdata must be valid the cycle after reg_rd_en.
`timescale 1ns/1ps
interface spi_3wire_responder_if #(
  parameter int ADDR_W = 10
);
  logic              spi_csn;
  logic              spi_clk;
  logic              spi_sdio_i;
  logic              spi_sdio_o;
  logic              spi_sdio_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wdata;
  logic              reg_rd_en;
  logic [7:0]        reg_rdata;
  logic              busy;

  modport master (
    output spi_csn, spi_clk, spi_sdio_i, reg_rdata,
    input  spi_sdio_o, spi_sdio_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy
  );

  modport slave (
    input  spi_csn, spi_clk, spi_sdio_i, reg_rdata,
    output spi_sdio_o, spi_sdio_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy
  );
endinterface

// File: rtl/spi_3wire_responder.sv
// 3-wire SPI responder: oversampled csn/clk/sdio, 16-bit instruction, byte-wide register-bank port.
// Build option SPI_RESP_STREAM_EN: unlimited data bytes per frame with address auto-increment.
`timescale 1ns/1ps
module spi_3wire_responder #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_3wire_responder_if.slave bus,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INSTR = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdio_sync_q;
  logic                   csn_prev_q;
  logic                   sclk_prev_q;
  logic                   csn_s;
  logic                   sclk_s;
  logic                   sdio_s;
  logic                   csn_fall;
  logic                   sclk_rise;
  logic                   sclk_fall;

  // csn synchronizer resets high so busy and csn_fall stay quiet out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      sdio_sync_q <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus.spi_csn};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
      sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], bus.spi_sdio_i};
      csn_prev_q  <= csn_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_t            state_q;
  logic [4:0]        bit_cnt_q;
  logic [15:0]       shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rnw_q;
  logic              wr_en_q;
  logic [7:0]        wdata_q;
  logic              rd_en_q;
  logic              cap_q;
  logic [7:0]        tx_q;
  logic              sdio_o_q;
  logic              oe_q;

  logic [15:0]       shift_d;
  logic [4:0]        bit_cnt_d;
  logic [ADDR_W-1:0] addr_inc_d;

  assign shift_d    = {shift_q[14:0], sdio_s};
  assign bit_cnt_d  = bit_cnt_q + 5'd1;
  assign addr_inc_d = addr_q + ADDR_W'(1);

  generate
    if (ADDR_W < 15) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^shift_d[14:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rnw_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      cap_q     <= 1'b0;
      tx_q      <= '0;
      sdio_o_q  <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      cap_q   <= rd_en_q;
      // write address advances the cycle after its strobe
      if (wr_en_q) addr_q <= addr_inc_d;

      if (csn_s) begin
        // csn high aborts everything, including a strobe due this cycle
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        rnw_q     <= 1'b0;
        cap_q     <= 1'b0;
        tx_q      <= '0;
        sdio_o_q  <= 1'b0;
        oe_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (csn_fall) begin
              state_q   <= S_INSTR;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end
          end
          S_INSTR: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 5'd15) begin
                bit_cnt_q <= '0;
                addr_q    <= shift_d[ADDR_W-1:0];
                rnw_q     <= shift_d[15];
                if (shift_d[15]) begin
                  state_q <= S_RDATA;
                  rd_en_q <= 1'b1;
                end else begin
                  state_q <= S_WDATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_WDATA: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                wr_en_q   <= 1'b1;
                wdata_q   <= shift_d[7:0];
`ifndef SPI_RESP_STREAM_EN
                state_q   <= S_HOLD;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          S_RDATA: begin
            if (sclk_rise) begin
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
`ifdef SPI_RESP_STREAM_EN
                addr_q    <= addr_inc_d;
                rd_en_q   <= 1'b1;
`else
                state_q   <= S_HOLD;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_d;
              end
            end
            if (sclk_fall) begin
              oe_q     <= 1'b1;
              sdio_o_q <= tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
            // load lands well before the next fall given spi_clk <= clk/8
            if (cap_q) tx_q <= bus.reg_rdata;
          end
          S_HOLD: begin
            if (sclk_fall && rnw_q) begin
              oe_q     <= 1'b1;
              sdio_o_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.spi_sdio_o  = sdio_o_q;
  assign bus.spi_sdio_oe = oe_q & ~csn_s;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.busy        = ~csn_s;
  assign state_o         = state_q;

endmodule
